seg_display_driver: RTL and testbench

Consumer end of the config/display interface driven by the wave generator's input handler. Samples a 20-bit binary value, a 4-bit config mode and a 3-bit cursor, converts the value to 6 BCD digits with a sequential double-dabble, and time-multiplexes an 8-digit common-anode 7-segment display. Digits 5..0 show the value, digit 7 shows a mode letter, digit 6 is blank. Sits between the input handler and the board's AN/SEG pins.

---
 rtl/seg_display_pkg.sv | 78 +++++++
 rtl/bin2bcd_seq.sv | 78 +++++++
 rtl/seg_display_driver.sv | 185 ++++++++++++++++++
 tb/tb_seg_display_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display driver.
//   - Config mode codes (shared with the wave generator's input handler)
//   - Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
//   - Binary-to-BCD converter state encoding
//   - Glyph lookup helpers
package seg_display_pkg;

  // Config mode codes driven by the input handler
  localparam logic [3:0] MODE_FREQ        = 4'd0;
  localparam logic [3:0] MODE_PHASE       = 4'd1;
  localparam logic [3:0] MODE_DUTY        = 4'd2;
  localparam logic [3:0] MODE_SWEEP_RANGE = 4'd3;
  localparam logic [3:0] MODE_SWEEP_SPEED = 4'd4;

  // Converter geometry
  localparam int         BIN_W   = 20;
  localparam int         BCD_W   = 24;
  localparam logic [19:0] BIN_MAX = 20'd999999;

  // Active-low glyphs, {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_R     = 7'h2F;
  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Converter FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] mode_glyph(input logic [3:0] m);
    logic [6:0] g;
    case (m)
      MODE_FREQ:        g = GLYPH_F;
      MODE_PHASE:       g = GLYPH_P;
      MODE_DUTY:        g = GLYPH_D;
      MODE_SWEEP_RANGE: g = GLYPH_R;
      MODE_SWEEP_SPEED: g = GLYPH_S;
      default:          g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a conversion (sampled in IDLE)
//   bin        : 20-bit binary input, snapshotted in LOAD and clamped to 999999
//   load       : high for the single LOAD cycle (lets the caller snapshot side data)
//   done       : high for the single DONE cycle; bcd is complete and stable then
//   bcd        : 6-digit packed BCD result, nibble 0 = units
// One conversion takes IDLE + LOAD + 20 x SHIFT + DONE = 23 cycles.
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              load,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  conv_state_e state, state_next;

  logic [4:0]       shift_cnt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < 6; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD: begin
        load       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (shift_cnt == 5'd19) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              shift_cnt <= '0;
    else if (state == LOAD)  shift_cnt <= '0;
    else if (state == SHIFT) shift_cnt <= shift_cnt + 5'd1;
  end

  // Shift register {bcd, bin}: adjust then shift, once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      bin_sh <= (bin > BIN_MAX) ? BIN_MAX : bin;
      bcd_sh <= '0;
    end else if (state == SHIFT) begin
      {bcd_sh, bin_sh} <= {dabble(bcd_sh), bin_sh} << 1;
    end
  end

  assign bcd = bcd_sh;

endmodule

// File: rtl/seg_display_driver.sv
// 8-digit common-anode 7-segment display driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   value_in   : 20-bit value, shown as 6 decimal digits on digits 5..0
//   mode_in    : config mode, shown as a letter on digit 7 (digit 6 blank)
//   cursor_in  : edited digit 0..5 (dp lit there), 6/7 = no cursor
//   an         : active-low one-hot digit enables
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
// Optional build macro CURSOR_BLINK_EN: blanks the cursor digit's segments
// on alternate half periods of BLINK_HZ (dp stays lit).
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 8000,
  parameter int BLINK_HZ   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] value_in,
  input  logic [3:0]  mode_in,
  input  logic [2:0]  cursor_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Converter and atomic display register

  logic              conv_load;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [3:0]        mode_snap;
  logic [BCD_W-1:0]  bcd_disp;
  logic [3:0]        mode_disp;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (1'b1),
    .bin   (value_in),
    .load  (conv_load),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // mode is captured with the value so both describe the same sample
  always_ff @(posedge clk) begin
    if (conv_load) mode_snap <= mode_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_disp  <= '0;
      mode_disp <= '0;
    end else if (conv_done) begin
      bcd_disp  <= conv_bcd;
      mode_disp <= mode_snap;
    end
  end

  // Cursor register, updated every cycle independently of the converter

  logic [2:0] cursor_reg;
  logic       cursor_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cursor_reg <= 3'd7;
    else        cursor_reg <= cursor_in;
  end

  assign cursor_valid = (cursor_reg <= 3'd5);

  // Blink phase

  logic blink_on;

`ifdef CURSOR_BLINK_EN
  localparam int HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HALF_W-1:0] blink_cnt;
  logic              cursor_chg;

  // a new cursor restarts a full ON half period so the edit is visible
  assign cursor_chg = (cursor_in != cursor_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (cursor_chg) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == HALF_W'(HALF - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  // without blinking the cursor digit stays lit; BLINK_HZ has no effect here
  localparam logic BLINK_STEADY = (BLINK_HZ > 0) || 1'b1;
  assign blink_on = BLINK_STEADY;
`endif

  // Scan divider

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Digit content for the current scan index

  logic [2:0] scan_idx;
  logic [3:0] nib [8];
  logic [7:0] upper_zero;
  logic       blank_lz;
  logic [6:0] digit_seg;
  logic       digit_dp;

  always_comb begin
    for (int k = 0; k < 6; k++) nib[k] = bcd_disp[4*k +: 4];
    nib[6] = 4'd0;
    nib[7] = 4'd0;
  end

  // upper_zero[k]: nibbles k..5 are all zero
  always_comb begin
    upper_zero    = '0;
    upper_zero[7] = 1'b1;
    upper_zero[6] = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] & (nib[k] == 4'd0);
    end
  end

  // leading zeros stay visible at and below the cursor so the edited digit
  // and its lower neighbours can be seen; with no cursor, all may blank
  assign blank_lz = (scan_idx != 3'd0) && upper_zero[scan_idx] &&
                    (!cursor_valid || (scan_idx > cursor_reg));

  always_comb begin
    digit_seg = GLYPH_BLANK;
    digit_dp  = 1'b1;
    if (scan_idx <= 3'd5) begin
      digit_seg = blank_lz ? GLYPH_BLANK : digit_glyph(nib[scan_idx]);
      if (cursor_valid && (scan_idx == cursor_reg)) begin
        digit_dp = 1'b0;
        if (!blink_on) digit_seg = GLYPH_BLANK;
      end
    end else if (scan_idx == 3'd7) begin
      digit_seg = mode_glyph(mode_disp);
    end
  end

  // Output register: the digit at scan_idx is presented on the tick,
  // and the index then advances to the next digit

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an       <= 8'hFF;
      seg      <= GLYPH_BLANK;
      dp       <= 1'b1;
      scan_idx <= '0;
    end else if (tick) begin
      an       <= ~(8'd1 << scan_idx);
      seg      <= digit_seg;
      dp       <= digit_dp;
      scan_idx <= scan_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;
  import seg_display_pkg::*;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30,
                         G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G9 = 7'h10,
                         GF = 7'h0E, GP = 7'h0C, GD = 7'h21, GR = 7'h2F,
                         GS = 7'h12, GDASH = 7'h3F, GB = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] value_in;
  logic [3:0]  mode_in;
  logic [2:0]  cursor_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  logic [6:0] last_seg [8];
  logic       last_dp  [8];
  logic       mon_en = 1'b0;
  int         mixed_bad = 0;

  seg_display_driver #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (100),
    .BLINK_HZ   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .mode_in   (mode_in),
    .cursor_in (cursor_in),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  // Latest seg/dp seen for each digit; optional glyph monitor for digits 0..5
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (an == ~(8'd1 << i)) begin
        last_seg[i] <= seg;
        last_dp[i]  <= dp;
        if (mon_en && i < 6 && seg !== G1 && seg !== G2) mixed_bad <= mixed_bad + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0][6:0] es, input logic [7:0] ed);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_seg%0d", tag, i), 32'(last_seg[i]), 32'(es[i]));
      chk($sformatf("%s_dp%0d", tag, i), 32'(last_dp[i]), 32'(ed[i]));
    end
  endtask

  // Release reset at a falling edge and expect the first tick 10 cycles later
  task automatic release_and_first_tick(input string tag);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (an == 8'hFF && n < 30);
    chk({tag, "_tick_cycles"}, 32'(n), 32'd10);
    chk({tag, "_tick_an"}, 32'(an), 32'hFE);
    chk({tag, "_tick_seg"}, 32'(seg), 32'(G0));
    chk({tag, "_tick_dp"}, 32'(dp), 32'd1);
  endtask

  initial begin
    int n;
    int seen_on;
    int seen_off;
    int seen_other;
    int dp_bad;
    int base;

    rst_n     = 1'b0;
    value_in  = 20'd0;
    mode_in   = 4'd0;
    cursor_in = 3'd7;

    // Power-on reset
    wait_cyc(3);
    chk("por_an", 32'(an), 32'hFF);
    chk("por_seg", 32'(seg), 32'h7F);
    chk("por_dp", 32'(dp), 32'd1);
    release_and_first_tick("por");

    // Conversion of 123456, mode F
    value_in = 20'd123456;
    mode_in  = 4'd0;
    wait_cyc(150);
    check_frame("conv", {GF, GB, G1, G2, G3, G4, G5, G6}, 8'hFF);

    // Asynchronous reset mid-frame
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    release_and_first_tick("mid_rst");

    // Leading-zero blanking around the cursor
    value_in  = 20'd42;
    cursor_in = 3'd7;
    wait_cyc(150);
    cursor_in = 3'd0;
    wait_cyc(95);
    check_frame("blank_c0", {GF, GB, GB, GB, GB, GB, G4, G2}, 8'hFE);
    cursor_in = 3'd4;
    wait_cyc(95);
    check_frame("blank_c4", {GF, GB, GB, G0, G0, G0, G4, G2}, 8'hEF);

    // Clamp to 999999 and mode glyphs
    cursor_in = 3'd7;
    value_in  = 20'hFFFFF;
    mode_in   = 4'd2;
    wait_cyc(150);
    check_frame("clamp_d", {GD, GB, G9, G9, G9, G9, G9, G9}, 8'hFF);
    mode_in = 4'd9;
    wait_cyc(150);
    chk("mode9_dash", 32'(last_seg[7]), 32'(GDASH));
    mode_in = 4'd1;
    wait_cyc(150);
    chk("mode1_p", 32'(last_seg[7]), 32'(GP));
    mode_in = 4'd3;
    wait_cyc(150);
    chk("mode3_r", 32'(last_seg[7]), 32'(GR));
    mode_in = 4'd4;
    wait_cyc(150);
    chk("mode4_s", 32'(last_seg[7]), 32'(GS));

    // Value change while the converter is shifting
    mode_in  = 4'd0;
    value_in = 20'd111111;
    wait_cyc(150);
    check_frame("old_val", {GF, GB, G1, G1, G1, G1, G1, G1}, 8'hFF);
    base   = mixed_bad;
    mon_en = 1'b1;
    n = 0;
    while (dut.u_conv.state != SHIFT && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("shift_reached", 32'(n < 50), 32'd1);
    wait_cyc(3);
    value_in = 20'd222222;
    wait_cyc(150);
    mon_en = 1'b0;
    @(negedge clk);
    chk("no_mixed_digits", 32'(mixed_bad - base), 32'd0);
    check_frame("new_val", {GF, GB, G2, G2, G2, G2, G2, G2}, 8'hFF);

    // Cursor digit behaviour
    value_in  = 20'd123456;
    cursor_in = 3'd7;
    wait_cyc(150);
    cursor_in = 3'd1;
    seen_on = 0; seen_off = 0; seen_other = 0; dp_bad = 0;
`ifdef CURSOR_BLINK_EN
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (an == 8'hFD) begin
        if (seg === G5)      seen_on++;
        else if (seg === GB) seen_off++;
        else                 seen_other++;
        if (dp !== 1'b0) dp_bad++;
      end
    end
    chk("blink_on_seen", 32'(seen_on > 0), 32'd1);
    chk("blink_off_seen", 32'(seen_off > 0), 32'd1);
    chk("blink_other", 32'(seen_other), 32'd0);
    chk("blink_dp_low", 32'(dp_bad), 32'd0);
    // Move the cursor while digit 1 is dark
    n = 0;
    while (!(an == 8'hFD && seg === GB) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("blink_off_found", 32'(n < 400), 32'd1);
    cursor_in = 3'd2;
    n = 0;
    while (an != 8'hFB && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("newcur_scan_found", 32'(n < 100), 32'd1);
    chk("newcur_seg_lit", 32'(seg), 32'(G4));
    chk("newcur_dp_low", 32'(dp), 32'd0);
`else
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (an == 8'hFD) begin
        if (seg === G5) seen_on++;
        else            seen_other++;
        if (dp !== 1'b0) dp_bad++;
      end
    end
    chk("cursor_lit_seen", 32'(seen_on > 0), 32'd1);
    chk("cursor_never_dark", 32'(seen_other), 32'd0);
    chk("cursor_dp_low", 32'(dp_bad), 32'd0);
    cursor_in = 3'd2;
    wait_cyc(95);
    chk("newcur_seg_lit", 32'(last_seg[2]), 32'(G4));
    chk("newcur_dp_low", 32'(last_dp[2]), 32'd0);
    chk("oldcur_dp_high", 32'(last_dp[1]), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
